// File: rtl/swap_rotate_bank.sv
// ---------------------------------------------------------------------------
// swap_rotate_bank
//
// A small bank of DEPTH registers, each WIDTH bits wide, that can be loaded
// one entry at a time and then permuted in place by a multi-cycle operation:
//   SWAP    (00) exchange entry[idx_a] and entry[idx_b]        (1 step)
//   ROTL    (01) entry[i] <= entry[i+1], repeated op_amt times (op_amt steps)
//   ROTR    (10) entry[i] <= entry[i-1], repeated op_amt times (op_amt steps)
//   REVERSE (11) entry[i] <= entry[DEPTH-1-i]                  (1 step)
// All index arithmetic wraps modulo DEPTH (DEPTH is a power of two).
//
// Ports
//   clk         in   single clock, all state moves on its rising edge
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   write request for one entry
//   load_ready  out  high in IDLE; a write fires on load_valid && load_ready
//   load_idx    in   entry index to write
//   load_data   in   data to write
//   op_valid    in   operation request
//   op_ready    out  high in IDLE when no load is requested this cycle
//   op_code     in   operation select (see table above)
//   idx_a/idx_b in   SWAP operand indices
//   op_amt      in   rotate amount in positions
//   rd_idx      in   combinational read index
//   rd_data     out  entry[rd_idx], valid in every state
//   busy        out  high whenever the controller is not IDLE
//   done        out  one-cycle pulse when an operation completes
// ---------------------------------------------------------------------------
module swap_rotate_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [AW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_data,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [AW-1:0]    idx_a,
  input  logic [AW-1:0]    idx_b,
  input  logic [AW-1:0]    op_amt,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operation encodings
  localparam logic [1:0] OP_SWAP = 2'b00;
  localparam logic [1:0] OP_ROTL = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_REV  = 2'b11;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [1:0]       opc_q, opc_d;
  logic [AW-1:0]    a_q, a_d;
  logic [AW-1:0]    b_q, b_d;
  logic [AW-1:0]    steps_q, steps_d;

  // Permuted view of the bank for one EXEC step of the latched operation
  logic [WIDTH-1:0] step_mem [DEPTH];

  logic load_fire;
  logic op_fire;
  logic op_is_rot;
  logic op_zero_rot;
  logic last_step;

  // -------------------------------------------------------------------------
  // Handshakes. A load and an op requested together: the load wins because
  // op_ready is masked by load_valid, so the op simply waits a cycle.
  // -------------------------------------------------------------------------
  assign load_ready  = (state_q == ST_IDLE);
  assign op_ready    = (state_q == ST_IDLE) && !load_valid;
  assign load_fire   = load_valid && load_ready;
  assign op_fire     = op_valid && op_ready;

  // A zero-length rotate has nothing to execute, so it skips EXEC entirely.
  assign op_is_rot   = (op_code == OP_ROTL) || (op_code == OP_ROTR);
  assign op_zero_rot = op_is_rot && (op_amt == '0);

  // steps_q holds the number of steps still to perform, including the
  // one happening at the current edge.
  assign last_step   = (steps_q == AW'(1));

  // -------------------------------------------------------------------------
  // One step of the latched operation, computed purely from the pre-edge
  // contents so every entry moves simultaneously. Indices are truncated to
  // AW bits, which gives the modulo-DEPTH wrap for free.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      step_mem[i] = mem_q[i];
    end
    case (opc_q)
      OP_SWAP: begin
        // Both writes read mem_q, so a == b degenerates to a no-op.
        step_mem[a_q] = mem_q[b_q];
        step_mem[b_q] = mem_q[a_q];
      end
      OP_ROTL: begin
        for (int i = 0; i < DEPTH; i++) begin
          step_mem[i] = mem_q[AW'(i + 1)];
        end
      end
      OP_ROTR: begin
        for (int i = 0; i < DEPTH; i++) begin
          step_mem[i] = mem_q[AW'(i + DEPTH - 1)];
        end
      end
      OP_REV: begin
        for (int i = 0; i < DEPTH; i++) begin
          step_mem[i] = mem_q[AW'(DEPTH - 1 - i)];
        end
      end
      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          step_mem[i] = mem_q[i];
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic for the controller, the latched op fields and the bank.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    steps_d = steps_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          mem_d[load_idx] = load_data;
        end else if (op_fire) begin
          opc_d   = op_code;
          a_d     = idx_a;
          b_d     = idx_b;
          steps_d = op_is_rot ? op_amt : AW'(1);
          state_d = op_zero_rot ? ST_DONE : ST_EXEC;
        end
      end

      ST_EXEC: begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = step_mem[i];
        end
        steps_d = steps_q - AW'(1);
        if (last_step) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. Reset clears the bank and any in-flight operation, so an
  // aborted operation can never produce a done pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      steps_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      steps_q <= steps_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The read port looks straight at the registers, so mid-rotate
  // reads show the partially rotated contents.
  // -------------------------------------------------------------------------
  assign rd_data = mem_q[rd_idx];
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_swap_rotate_bank.sv
// ---------------------------------------------------------------------------
// tb_swap_rotate_bank
//
// Directed bench for swap_rotate_bank (DEPTH=4, WIDTH=32). A reference model
// describes each operation as a whole permutation of a snapshot taken at
// accept time, indexed by how many steps have elapsed; a compare process
// checks every DUT output against it on each falling edge. Hand-computed
// literal reads pin the model to known results.
// ---------------------------------------------------------------------------
module tb_swap_rotate_bank;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [AW-1:0]    load_idx;
  logic [WIDTH-1:0] load_data;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [AW-1:0]    idx_a;
  logic [AW-1:0]    idx_b;
  logic [AW-1:0]    op_amt;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;

  int checks    = 0;
  int failures  = 0;
  int doneCount = 0;
  int busyCount = 0;
  bit chkEn     = 1'b0;

  swap_rotate_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .idx_a      (idx_a),
    .idx_b      (idx_b),
    .op_amt     (op_amt),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done)
  );

  always #10 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model: committed contents, plus the snapshot and elapsed-step
  // count of the operation in flight.
  // -------------------------------------------------------------------------
  int unsigned mEnt  [DEPTH];
  int unsigned mOrig [DEPTH];
  int unsigned mTmp  [DEPTH];
  int          mOp, mA, mB, mN, mE;
  bit          mActive = 1'b0;

  // Contents of the snapshot after k steps of the latched operation
  function automatic int unsigned permuted(int i, int k);
    int unsigned r;
    r = mOrig[i];
    case (mOp)
      0: begin
        if (k > 0) begin
          if (i == mA) r = mOrig[mB];
          else if (i == mB) r = mOrig[mA];
        end
      end
      1: r = mOrig[(i + k) % DEPTH];
      2: r = mOrig[(i - k + DEPTH) % DEPTH];
      default: begin
        if (k > 0) r = mOrig[DEPTH - 1 - i];
      end
    endcase
    return r;
  endfunction

  function automatic int unsigned modelEntry(int i);
    int k;
    k = (mE < mN) ? mE : mN;
    if (!mActive) return mEnt[i];
    return permuted(i, k);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mEnt[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) mEnt[i] = 0;
        mActive = 1'b0;
        mE = 0;
        mN = 0;
      end else if (!mActive) begin
        if (load_valid) begin
          mEnt[int'(load_idx)] = load_data;
        end else if (op_valid) begin
          for (int i = 0; i < DEPTH; i++) mOrig[i] = mEnt[i];
          mOp = int'(op_code);
          mA  = int'(idx_a);
          mB  = int'(idx_b);
          mN  = (op_code == 2'b01 || op_code == 2'b10) ? int'(op_amt) : 1;
          mE  = 0;
          mActive = 1'b1;
        end
      end else begin
        mE++;
        if (mE == mN + 1) begin
          for (int i = 0; i < DEPTH; i++) mTmp[i] = permuted(i, mN);
          for (int i = 0; i < DEPTH; i++) mEnt[i] = mTmp[i];
          mActive = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Comparison helper shared by the compare process and the literal checks
  // -------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Every falling edge: compare all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chkEn) begin
        checkOutput("cmp_busy", 32'(busy), 32'(mActive));
        checkOutput("cmp_done", 32'(done), 32'(mActive && (mE == mN)));
        checkOutput("cmp_load_ready", 32'(load_ready), 32'(!mActive));
        checkOutput("cmp_op_ready", 32'(op_ready), 32'(!mActive && !load_valid));
        checkOutput("cmp_rd_data", rd_data, modelEntry(int'(rd_idx)));
        if (done === 1'b1) doneCount++;
        if (busy === 1'b1) busyCount++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_idx = rd_idx + 1'b1;
  endtask

  task automatic applyStimulus(input logic lv, input logic [AW-1:0] li, input logic [31:0] ld,
                               input logic ov, input logic [1:0] oc, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic [AW-1:0] amt);
    load_valid = lv;
    load_idx   = li;
    load_data  = ld;
    op_valid   = ov;
    op_code    = oc;
    idx_a      = a;
    idx_b      = b;
    op_amt     = amt;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic loadEntry(input logic [AW-1:0] idx, input logic [31:0] data);
    applyStimulus(1'b1, idx, data, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    tick();
    idleInputs();
  endtask

  task automatic load4(input logic [31:0] d0, d1, d2, d3);
    loadEntry(2'd0, d0);
    loadEntry(2'd1, d1);
    loadEntry(2'd2, d2);
    loadEntry(2'd3, d3);
  endtask

  // Returns in the cycle right after the accept edge
  task automatic startOp(input logic [1:0] oc, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [AW-1:0] amt);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, oc, a, b, amt);
    tick();
    idleInputs();
  endtask

  // Bounded wait for done, then one more cycle to get back to IDLE
  task automatic waitDone(input string name);
    int found;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      tick();
    end
    checkOutput({name, "_done_seen"}, found, 1);
    tick();
  endtask

  task automatic readCheck(input string name, input logic [AW-1:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    #1;
    checkOutput(name, rd_data, exp);
  endtask

  task automatic check4(input string name, input logic [31:0] e0, e1, e2, e3);
    readCheck({name, "_e0"}, 2'd0, e0);
    readCheck({name, "_e1"}, 2'd1, e1);
    readCheck({name, "_e2"}, 2'd2, e2);
    readCheck({name, "_e3"}, 2'd3, e3);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int dc0;
    int bc0;
    rst_n  = 1'b1;
    rd_idx = '0;
    idleInputs();
    #2;
    rst_n = 1'b0;
    chkEn = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    readCheck("rst_rd0", 2'd0, 0);
    readCheck("rst_rd3", 2'd3, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_load_ready", 32'(load_ready), 1);
    checkOutput("post_rst_op_ready", 32'(op_ready), 1);

    // SWAP a=0 b=1 on entry0=30, entry1=20
    loadEntry(2'd0, 32'd30);
    loadEntry(2'd1, 32'd20);
    dc0 = doneCount;
    bc0 = busyCount;
    startOp(2'b00, 2'd0, 2'd1, 2'd0);
    checkOutput("swap_busy_exec", 32'(busy), 1);
    readCheck("swap_pre_rd0", 2'd0, 30);
    tick();
    checkOutput("swap_done_pulse", 32'(done), 1);
    readCheck("swap_rd0", 2'd0, 20);
    readCheck("swap_rd1", 2'd1, 30);
    tick();
    checkOutput("swap_done_low", 32'(done), 0);
    checkOutput("swap_busy_low", 32'(busy), 0);
    checkOutput("swap_done_count", doneCount - dc0, 1);
    checkOutput("swap_busy_cycles", busyCount - bc0, 2);

    // ROTL by 3 with mid-rotate reads of entry 0
    load4(32'd10, 32'd20, 32'd30, 32'd40);
    dc0 = doneCount;
    startOp(2'b01, 2'd0, 2'd0, 2'd3);
    readCheck("rotl_step0_rd0", 2'd0, 10);
    tick();
    readCheck("rotl_step1_rd0", 2'd0, 20);
    checkOutput("rotl_step1_done", 32'(done), 0);
    tick();
    readCheck("rotl_step2_rd0", 2'd0, 30);
    tick();
    readCheck("rotl_step3_rd0", 2'd0, 40);
    checkOutput("rotl_done_pulse", 32'(done), 1);
    tick();
    checkOutput("rotl_done_low", 32'(done), 0);
    check4("rotl_final", 32'd40, 32'd10, 32'd20, 32'd30);
    checkOutput("rotl_done_count", doneCount - dc0, 1);

    // REVERSE, then a zero-length ROTR
    load4(32'd1, 32'd2, 32'd3, 32'd4);
    startOp(2'b11, 2'd0, 2'd0, 2'd0);
    waitDone("rev");
    check4("rev_final", 32'd4, 32'd3, 32'd2, 32'd1);
    dc0 = doneCount;
    startOp(2'b10, 2'd0, 2'd0, 2'd0);
    checkOutput("rotr0_done_immediate", 32'(done), 1);
    check4("rotr0_mid", 32'd4, 32'd3, 32'd2, 32'd1);
    tick();
    checkOutput("rotr0_done_low", 32'(done), 0);
    check4("rotr0_final", 32'd4, 32'd3, 32'd2, 32'd1);
    checkOutput("rotr0_done_count", doneCount - dc0, 1);

    // Load and op requested together: load wins, op follows next cycle
    applyStimulus(1'b1, 2'd2, 32'd99, 1'b1, 2'b00, 2'd0, 2'd1, 2'd0);
    #1;
    checkOutput("conflict_op_ready", 32'(op_ready), 0);
    checkOutput("conflict_load_ready", 32'(load_ready), 1);
    tick();
    checkOutput("conflict_not_busy", 32'(busy), 0);
    load_valid = 1'b0;
    #1;
    checkOutput("conflict_op_ready_after", 32'(op_ready), 1);
    tick();
    idleInputs();
    checkOutput("conflict_op_taken", 32'(busy), 1);
    waitDone("conflict");
    check4("conflict_final", 32'd3, 32'd4, 32'd99, 32'd1);

    // Reset in the middle of ROTL by 3
    load4(32'd10, 32'd20, 32'd30, 32'd40);
    dc0 = doneCount;
    startOp(2'b01, 2'd0, 2'd0, 2'd3);
    tick();
    readCheck("abort_step1_rd0", 2'd0, 20);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    check4("abort_cleared", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abort_no_done", doneCount - dc0, 0);
    loadEntry(2'd0, 32'd7);
    loadEntry(2'd1, 32'd8);
    startOp(2'b00, 2'd1, 2'd0, 2'd0);
    waitDone("abort_swap");
    readCheck("abort_swap_rd0", 2'd0, 8);
    readCheck("abort_swap_rd1", 2'd1, 7);
    readCheck("abort_swap_rd2", 2'd2, 0);

    // SWAP with equal indices leaves the bank unchanged
    load4(32'd5, 32'd6, 32'd7, 32'd8);
    dc0 = doneCount;
    startOp(2'b00, 2'd2, 2'd2, 2'd0);
    waitDone("swap_same");
    check4("swap_same_final", 32'd5, 32'd6, 32'd7, 32'd8);
    checkOutput("swap_same_done_count", doneCount - dc0, 1);

    // ROTR by 2, with load and op requests ignored while busy
    startOp(2'b10, 2'd0, 2'd0, 2'd2);
    applyStimulus(1'b1, 2'd0, 32'hdead, 1'b1, 2'b00, 2'd0, 2'd3, 2'd0);
    tick();
    idleInputs();
    waitDone("rotr2");
    check4("rotr2_final", 32'd7, 32'd8, 32'd5, 32'd6);

    // SWAP across the wrap boundary indices 3 and 0
    startOp(2'b00, 2'd3, 2'd0, 2'd0);
    waitDone("swap_wrap");
    check4("swap_wrap_final", 32'd6, 32'd8, 32'd5, 32'd7);

    tick();
    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swap_rotate_bank.md
SWAP_ROTATE_BANK -- requirements
Module: swap_rotate_bank

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each register entry.
REQ-002 Parameter DEPTH, default 4: number of entries; SHALL be a power of two and at least 2. AW = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates occur on the posedge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 load_valid  input  1  write request for one entry.
REQ-006 load_ready  output  1  write accepted when load_valid && load_ready.
REQ-007 load_idx  input  AW  entry index to write.
REQ-008 load_data  input  WIDTH  write data.
REQ-009 op_valid  input  1  operation request.
REQ-010 op_ready  output  1  operation accepted when op_valid && op_ready.
REQ-011 op_code  input  2  operation select: 00 SWAP, 01 ROTL, 10 ROTR, 11 REVERSE.
REQ-012 idx_a, idx_b  input  AW each  SWAP operand indices.
REQ-013 op_amt  input  AW  rotate amount, in positions.
REQ-014 rd_idx  input  AW  read index.
REQ-015 rd_data  output  WIDTH  combinational read: rd_data = entry[rd_idx].
REQ-016 busy  output  1  high while state != IDLE.
REQ-017 done  output  1  one-cycle pulse on operation completion.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and DONE.
REQ-019 load_ready = (state == IDLE).
REQ-020 op_ready = (state == IDLE) && !load_valid; a load takes priority over an op in the same cycle.
REQ-021 Accepted load SHALL write entry[load_idx] <= load_data at the same edge; the FSM stays in IDLE.
REQ-022 On op accept, the block SHALL latch op_code, idx_a, idx_b and a step count, then move to EXEC. The step count is 1 for SWAP and REVERSE, and op_amt for ROTL/ROTR.
REQ-023 Rotate with op_amt == 0 SHALL go from IDLE directly to DONE with no entry change.
REQ-024 Each EXEC edge SHALL perform one step, with all entries updated simultaneously from pre-edge values (no read-after-write within a step).
- SWAP: entry[a] <= entry[b] and entry[b] <= entry[a].
- ROTL: entry[i] <= entry[(i+1) mod DEPTH].
- ROTR: entry[i] <= entry[(i-1) mod DEPTH].
- REVERSE: entry[i] <= entry[DEPTH-1-i].
REQ-025 After the last step the FSM SHALL enter DONE. In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 Latency: op accepted at edge T. Entries are final at edge T+n (n = step count). done is high in the cycle after edge T+n. op_ready can be high again after edge T+n+1.
REQ-027 SWAP with idx_a == idx_b SHALL leave entries unchanged and still complete with done.
REQ-028 Index arithmetic SHALL wrap modulo DEPTH with no error condition.
REQ-029 Inputs not accepted (valid low or ready low) SHALL have no effect; op fields are sampled only at accept.
REQ-030 rd_data SHALL be valid in every state, including mid-rotate, where it shows partially rotated contents.

Reset
REQ-031 rst_n low SHALL immediately set all entries to 0, state to IDLE, busy=0 and done=0, and clear latched op fields and the step counter.
REQ-032 Reset during EXEC or DONE SHALL abort the operation; no done pulse is issued for it.
REQ-033 After rst_n deasserts, load_ready=1 and op_ready=!load_valid on the first cycle.

Verification
REQ-034 DEPTH=4, WIDTH=32. Load entry0=30, entry1=20, then SWAP a=0 b=1 -> entry0=20 and entry1=30 at edge T+1; done pulses one cycle; busy high for 2 cycles.
REQ-035 Load [10,20,30,40], then ROTL op_amt=3 -> entries [40,10,20,30] after 3 EXEC edges; done exactly one cycle; rd_idx=0 reads 20, 30, 40 after steps 1, 2 and 3 respectively.
REQ-036 Load [1,2,3,4], then REVERSE -> [4,3,2,1]; then ROTR op_amt=0 -> no change, done in the cycle after accept.
REQ-037 load_valid and op_valid both high in IDLE -> load written, op_ready=0, op not accepted; op accepted the next cycle once load_valid drops.
REQ-038 Assert rst_n low mid-ROTL (op_amt=3, after step 1) -> entries 0, busy=0, no done pulse; a subsequent load and SWAP operate normally.
REQ-039 SWAP a=2 b=2 on [5,6,7,8] -> unchanged, done pulses once.
